// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA controller channel arbiter.
package dmac_pkg;

  localparam int DMAC_NUM_CH = 6;
  localparam int DMAC_CH_W   = 3;
  localparam int DMAC_BEAT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_t;

  // Next channel index in round-robin order, wrapping 5 -> 0.
  function automatic logic [DMAC_CH_W-1:0] dmac_ch_next(input logic [DMAC_CH_W-1:0] ch);
    return (ch == DMAC_CH_W'(DMAC_NUM_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

endpackage

// File: rtl/dmac_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, modulo 6.
module dmac_rr_pick
  import dmac_pkg::*;
(
  input  logic [DMAC_NUM_CH-1:0] ch_req,
  input  logic [DMAC_CH_W-1:0]   rr_ptr,
  output logic [DMAC_CH_W-1:0]   winner,
  output logic                   any_req
);

  logic [DMAC_CH_W-1:0] idx;
  logic                 found;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    winner  = rr_ptr;
    any_req = |ch_req;
    found   = 1'b0;
    idx     = rr_ptr;
    for (int i = 0; i < DMAC_NUM_CH; i++) begin
      if (!found && ch_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
      idx = dmac_ch_next(idx);
    end
  end

endmodule

// File: rtl/dmac_ch_arbiter.sv
// Six-channel round-robin arbiter driving the master-port mux select.
// Optional beat quantum per grant: define DMAC_ARB_QUANTUM_EN.
module dmac_ch_arbiter
  import dmac_pkg::*;
#(
  parameter int NUM_CH    = DMAC_NUM_CH,
  parameter int CH_W      = DMAC_CH_W,
  parameter int MAX_BEATS = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              dmac_en,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic              ch_done,
  input  logic              beat,
  output logic [NUM_CH-1:0] ch_grant,
  output logic [CH_W-1:0]   DMACActivedChannel,
  output logic              arb_busy
);

  arb_state_t        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   winner;
  logic              any_req;
  logic              quantum_hit;
  logic              exit_grant;

  dmac_rr_pick u_pick (
    .ch_req  (ch_req),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // grant_q is one-hot in GRANT, so masking with ch_req tests the owner's request.
  assign exit_grant = ch_done | ~(|(grant_q & ch_req)) | ~dmac_en | quantum_hit;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        if (dmac_en && any_req) begin
          state_d         = ARB_GRANT;
          sel_d           = winner;
          grant_d[winner] = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (exit_grant) begin
          state_d = ARB_RELEASE;
          grant_d = '0;
        end
      end
      ARB_RELEASE: begin
        grant_d  = '0;
        rr_ptr_d = dmac_ch_next(sel_q);
        state_d  = ARB_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments and a synchronous reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef DMAC_ARB_QUANTUM_EN
  localparam logic [DMAC_BEAT_W-1:0] QUANTUM_LAST = DMAC_BEAT_W'(MAX_BEATS - 1);

  logic [DMAC_BEAT_W-1:0] beat_cnt_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      beat_cnt_q <= '0;
    end else if (state_q == ARB_IDLE && state_d == ARB_GRANT) begin
      beat_cnt_q <= '0;
    end else if (state_q == ARB_GRANT && beat) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  // The beat that brings the count to MAX_BEATS ends the grant on the same edge.
  assign quantum_hit = (state_q == ARB_GRANT) && beat && (beat_cnt_q == QUANTUM_LAST);
`else
  logic unused_cfg;
  assign unused_cfg  = beat | (MAX_BEATS == 0);
  assign quantum_hit = 1'b0;
`endif

  assign ch_grant           = grant_q;
  assign DMACActivedChannel = sel_q;
  assign arb_busy           = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_dmac_ch_arbiter.sv
// Directed self-checking bench for dmac_ch_arbiter (MAX_BEATS = 4).
module tb_dmac_ch_arbiter;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       dmac_en;
  logic [5:0] ch_req;
  logic       ch_done;
  logic       beat;
  logic [5:0] ch_grant;
  logic [2:0] DMACActivedChannel;
  logic       arb_busy;

  int n_pass  = 0;
  int n_total = 0;

  dmac_ch_arbiter #(
    .NUM_CH    (6),
    .CH_W      (3),
    .MAX_BEATS (4)
  ) dut (
    .hclk               (hclk),
    .hreset             (hreset),
    .dmac_en            (dmac_en),
    .ch_req             (ch_req),
    .ch_done            (ch_done),
    .beat               (beat),
    .ch_grant           (ch_grant),
    .DMACActivedChannel (DMACActivedChannel),
    .arb_busy           (arb_busy)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset  = 1'b1;
    dmac_en = 1'b0;
    ch_req  = '0;
    ch_done = 1'b0;
    beat    = 1'b0;
    tick();
    tick();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({ch_grant, DMACActivedChannel, arb_busy} !== {6'b0, 3'd0, 1'b0})
      $display("FAIL reset_state: got grant=%b sel=%0d busy=%b want 000000/0/0", ch_grant, DMACActivedChannel, arb_busy);
    else n_pass++;
    ch_req = 6'b000100;
    tick();
    n_total++;
    if (ch_grant !== 6'b0)
      $display("FAIL disabled_no_grant: got grant=%b want 000000", ch_grant);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    dmac_en = 1'b1;
    ch_req  = 6'b000100;
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel, arb_busy} !== {6'b000100, 3'd2, 1'b1})
      $display("FAIL single_grant: got grant=%b sel=%0d busy=%b want 000100/2/1", ch_grant, DMACActivedChannel, arb_busy);
    else n_pass++;
    ch_req = 6'b000000;
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel, arb_busy} !== {6'b0, 3'd2, 1'b1})
      $display("FAIL req_drop_release: got grant=%b sel=%0d busy=%b want 000000/2/1", ch_grant, DMACActivedChannel, arb_busy);
    else n_pass++;
    tick();
    n_total++;
    if ({ch_grant, arb_busy} !== {6'b0, 1'b0})
      $display("FAIL req_drop_idle: got grant=%b busy=%b want 000000/0", ch_grant, arb_busy);
    else n_pass++;
  endtask

  task automatic test_rr_order();
    int exp_order[7] = '{0, 1, 2, 3, 4, 5, 0};
    logic [5:0] exp_grant;
    do_reset();
    dmac_en = 1'b1;
    ch_req  = 6'b111111;
    for (int k = 0; k < 7; k++) begin
      exp_grant = 6'b000001 << exp_order[k];
      tick();
      n_total++;
      if ({ch_grant, DMACActivedChannel} !== {exp_grant, 3'(exp_order[k])})
        $display("FAIL rr_grant[%0d]: got grant=%b sel=%0d want %b/%0d", k, ch_grant, DMACActivedChannel, exp_grant, exp_order[k]);
      else n_pass++;
      ch_done = 1'b1;
      tick();
      ch_done = 1'b0;
      n_total++;
      if ({ch_grant, DMACActivedChannel, arb_busy} !== {6'b0, 3'(exp_order[k]), 1'b1})
        $display("FAIL rr_release[%0d]: got grant=%b sel=%0d busy=%b want 000000/%0d/1", k, ch_grant, DMACActivedChannel, arb_busy, exp_order[k]);
      else n_pass++;
      tick();
      n_total++;
      if ({ch_grant, arb_busy} !== {6'b0, 1'b0})
        $display("FAIL rr_idle[%0d]: got grant=%b busy=%b want 000000/0", k, ch_grant, arb_busy);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    dmac_en = 1'b1;
    ch_req  = 6'b100000;
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel} !== {6'b100000, 3'd5})
      $display("FAIL wrap_grant5: got grant=%b sel=%0d want 100000/5", ch_grant, DMACActivedChannel);
    else n_pass++;
    ch_req = 6'b100001;
    tick();
    n_total++;
    if (ch_grant !== 6'b100000)
      $display("FAIL wrap_hold_ignores_other: got grant=%b want 100000", ch_grant);
    else n_pass++;
    ch_done = 1'b1;
    tick();
    ch_done = 1'b0;
    tick();
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel} !== {6'b000001, 3'd0})
      $display("FAIL wrap_next_ch0: got grant=%b sel=%0d want 000001/0", ch_grant, DMACActivedChannel);
    else n_pass++;
  endtask

  task automatic test_quantum();
    do_reset();
    dmac_en = 1'b1;
    ch_req  = 6'b000011;
    beat    = 1'b1;
    tick();
    n_total++;
    if (ch_grant !== 6'b000001)
      $display("FAIL quantum_first_grant: got grant=%b want 000001", ch_grant);
    else n_pass++;
`ifdef DMAC_ARB_QUANTUM_EN
    tick();
    tick();
    tick();
    n_total++;
    if (ch_grant !== 6'b000001)
      $display("FAIL quantum_hold_3beats: got grant=%b want 000001", ch_grant);
    else n_pass++;
    tick();
    n_total++;
    if ({ch_grant, arb_busy} !== {6'b0, 1'b1})
      $display("FAIL quantum_release: got grant=%b busy=%b want 000000/1", ch_grant, arb_busy);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel} !== {6'b000010, 3'd1})
      $display("FAIL quantum_next_ch1: got grant=%b sel=%0d want 000010/1", ch_grant, DMACActivedChannel);
    else n_pass++;
`else
    for (int i = 0; i < 12; i++) tick();
    n_total++;
    if ({ch_grant, arb_busy} !== {6'b000001, 1'b1})
      $display("FAIL no_quantum_hold: got grant=%b busy=%b want 000001/1", ch_grant, arb_busy);
    else n_pass++;
`endif
    beat = 1'b0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    dmac_en = 1'b1;
    ch_req  = 6'b001000;
    tick();
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel} !== {6'b001000, 3'd3})
      $display("FAIL en_grant3: got grant=%b sel=%0d want 001000/3", ch_grant, DMACActivedChannel);
    else n_pass++;
    dmac_en = 1'b0;
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel, arb_busy} !== {6'b0, 3'd3, 1'b1})
      $display("FAIL en_drop_release: got grant=%b sel=%0d busy=%b want 000000/3/1", ch_grant, DMACActivedChannel, arb_busy);
    else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel, arb_busy} !== {6'b0, 3'd3, 1'b0})
      $display("FAIL en_low_no_grant: got grant=%b sel=%0d busy=%b want 000000/3/0", ch_grant, DMACActivedChannel, arb_busy);
    else n_pass++;
    dmac_en = 1'b1;
    tick();
    n_total++;
    if (ch_grant !== 6'b001000)
      $display("FAIL en_regrant3: got grant=%b want 001000", ch_grant);
    else n_pass++;
  endtask

  task automatic test_multi_exit();
    do_reset();
    dmac_en = 1'b1;
    ch_req  = 6'b000010;
    tick();
    ch_done = 1'b1;
    ch_req  = 6'b000000;
    dmac_en = 1'b0;
    tick();
    ch_done = 1'b0;
    dmac_en = 1'b1;
    ch_req  = 6'b000011;
    n_total++;
    if ({ch_grant, arb_busy} !== {6'b0, 1'b1})
      $display("FAIL multi_exit_release: got grant=%b busy=%b want 000000/1", ch_grant, arb_busy);
    else n_pass++;
    tick();
    n_total++;
    if ({ch_grant, arb_busy} !== {6'b0, 1'b0})
      $display("FAIL multi_exit_idle: got grant=%b busy=%b want 000000/0", ch_grant, arb_busy);
    else n_pass++;
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel} !== {6'b000001, 3'd0})
      $display("FAIL served_lowest_prio: got grant=%b sel=%0d want 000001/0", ch_grant, DMACActivedChannel);
    else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    dmac_en = 1'b1;
    ch_req  = 6'b000100;
    tick();
    ch_req = 6'b000000;
    tick();
    tick();
    ch_req = 6'b010000;
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel} !== {6'b010000, 3'd4})
      $display("FAIL rst_mid_grant4: got grant=%b sel=%0d want 010000/4", ch_grant, DMACActivedChannel);
    else n_pass++;
    hreset = 1'b1;
    ch_req = 6'b111111;
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel, arb_busy} !== {6'b0, 3'd0, 1'b0})
      $display("FAIL rst_mid_clear: got grant=%b sel=%0d busy=%b want 000000/0/0", ch_grant, DMACActivedChannel, arb_busy);
    else n_pass++;
    hreset = 1'b0;
    tick();
    n_total++;
    if ({ch_grant, DMACActivedChannel} !== {6'b000001, 3'd0})
      $display("FAIL rst_rr_ptr_zero: got grant=%b sel=%0d want 000001/0", ch_grant, DMACActivedChannel);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_wrap();
    test_quantum();
    test_enable_drop();
    test_multi_exit();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmac_ch_arbiter.md
# dmac_ch_arbiter

Six-channel round-robin arbiter for the DMA controller master port. It takes per-channel transfer requests, grants the AHB master interface to one channel at a time, and drives `DMACActivedChannel`, the select of the downstream hwdata/address muxes. It guarantees that the select only changes across a one-cycle idle gap, so a data beat is never split between channels.

## Interface
Parameters:
- `NUM_CH`, 6: number of channels. Fixed at 6 so that it matches the 6:1 datapath muxes.
- `CH_W`, 3: width of the channel index.
- `MAX_BEATS`, 16: beat quantum per grant. Used only with `DMAC_ARB_QUANTUM_EN`. Legal range is 1..255.

Ports:
- `hclk` in 1: single system clock. All logic is on the rising edge.
- `hreset` in 1: synchronous, active-high reset.
- `dmac_en` in 1: global controller enable. When low, no new grants are issued.
- `ch_req` in 6: level request per channel. Held high while the channel has data to move.
- `ch_done` in 1: one-cycle pulse from the active channel engine when its block transfer completes.
- `beat` in 1: one accepted data beat on the master port (`htrans` NONSEQ/SEQ with `hready`).
- `ch_grant` out 6: registered one-hot grant, or all-zero.
- `DMACActivedChannel` out 3: registered index of the granted or last-granted channel. Always in the range 0..5.
- `arb_busy` out 1: high in GRANT and RELEASE.

## Operation
The arbiter has three states: IDLE, GRANT and RELEASE.

IDLE:
- If `dmac_en` is high and `ch_req` is non-zero, pick the winner with round-robin order starting at `rr_ptr`. Search `rr_ptr`, `rr_ptr`+1, … modulo 6.
- Register the winner into `DMACActivedChannel`, set `ch_grant[winner]`, and go to GRANT.
- Otherwise stay in IDLE with `ch_grant` = 0. `DMACActivedChannel` holds its value.

GRANT:
- Hold the grant.
- Exit to RELEASE on the first of these events:
  - `ch_done` pulses.
  - The granted channel's `ch_req` drops.
  - `dmac_en` drops.
  - The quantum expires (macro builds only).
- On exit, `ch_grant` is cleared. `DMACActivedChannel` is unchanged.

RELEASE:
- One cycle with `ch_grant` = 0.
- `rr_ptr` is updated to (granted index + 1) mod 6, wrapping 5→0.
- Go to IDLE.

Other rules:
- `rr_ptr` is only updated in RELEASE. A channel that has just been served therefore has the lowest priority in the next arbitration.
- When several exit events occur in the same cycle, they cause a single transition to RELEASE. `ch_done` has no extra effect beyond that.
- Requests from non-granted channels during GRANT are ignored until the next IDLE.
- `beat` while not in GRANT is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `ch_grant` = 0.
  - `DMACActivedChannel` = 0.
  - `arb_busy` = 0.
  - `rr_ptr` = 0.
  - Quantum counter = 0.
- Reset asserted in any state returns to these values on the next edge. Any grant in progress is dropped with no RELEASE cycle.
- Latency from request to grant: 1 cycle. If `ch_req` is sampled high in IDLE at edge N, `ch_grant` and `DMACActivedChannel` are valid after edge N.
- An exit event sampled at edge M clears the grant after edge M. State is RELEASE for cycle M+1. The earliest new grant is after edge M+2.
- The minimum gap between grants is 1 idle cycle (RELEASE), plus the IDLE arbitration edge.
- `DMACActivedChannel` changes only on the IDLE→GRANT transition, so it is stable for every cycle in which `ch_grant` is non-zero.

## Configuration
`DMAC_ARB_QUANTUM_EN`

Defined:
- An 8-bit beat counter is cleared on entry to GRANT and incremented on each `beat` while in GRANT.
- When the counter reaches `MAX_BEATS`, that counts as an exit event, and the channel is forced to RELEASE even if `ch_req` is still high.
- The channel then re-competes in round-robin order from `rr_ptr`.

Undefined:
- There is no counter and `beat` is unused.
- The grant is held until `ch_done`, `ch_req` drop, or `dmac_en` drop.

## Structure
Shared package `dmac_pkg` holds:
- `DMAC_NUM_CH` = 6.
- `DMAC_CH_W` = 3.
- The enumeration `arb_state_t` = {ARB_IDLE, ARB_GRANT, ARB_RELEASE}.

Sub-module: `dmac_rr_pick`, a combinational priority rotator. It takes `ch_req` [6] and `rr_ptr` [3] and produces `winner` [3] and `any_req`. It handles the mod-6 wrap explicitly; pointer values 6 and 7 never occur.

## Test plan
- Reset, then `ch_req`=6'b000100 with `dmac_en`=1 → `ch_grant`=6'b000100 and `DMACActivedChannel`=2 after one edge; `arb_busy`=1.
- `ch_req`=6'b111111 held, each grant ended by `ch_done` → grant order is 0,1,2,3,4,5,0, with exactly one zero-grant RELEASE cycle plus one IDLE cycle between grants.
- Granted channel is 5, then `ch_req`=6'b100001 → next grant goes to 0 (`rr_ptr` wraps 5→0).
- Quantum build with `MAX_BEATS`=4, `ch_req`=6'b000011, `beat` held high → ch0 is released after 4 beats and ch1 is granted next; without the macro, ch0 holds the grant indefinitely.
- Mid-GRANT on ch3, drop `dmac_en` → grant clears at the next edge, RELEASE follows, and no new grant is issued while `dmac_en`=0.
- Assert `hreset` during GRANT on ch4 → the next edge gives `ch_grant`=0, `DMACActivedChannel`=0 and `rr_ptr`=0.
